// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the imem/dmem memory arbiter: FSM state encoding,
//   transaction owner encoding and default widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int IMEM_ADDR_W    = 16;
    // Wide enough for the largest legal STARVE_MAX (15).
    localparam int STARVE_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // OWN_I is the reset value of the owner register.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant
//   Grant decision for the shared RAM port plus the saturating counter that
//   bounds how many dmem grants may overtake a waiting fetch.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   idle_i        arbiter FSM is in IDLE
//   dmem_oe_i     data-port request
//   imem_oe_i     fetch request pulse this cycle
//   ipend_i       latched fetch request waiting
//   dmem_ready_o  data port may be accepted this cycle
//   grant_d_o     data request is granted this cycle
//   grant_i_o     fetch is granted this cycle
module mem_arb_grant
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic idle_i,
    input  logic dmem_oe_i,
    input  logic imem_oe_i,
    input  logic ipend_i,
    output logic dmem_ready_o,
    output logic grant_d_o,
    output logic grant_i_o
);

    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    fetch_waiting;
    logic                    starved;

    assign fetch_waiting = ipend_i || imem_oe_i;

    // Only the latched request can block dmem, so dmem_ready never depends
    // combinationally on either request input.
    assign starved      = ipend_i && (starve_cnt_q == CNT_MAX);
    assign dmem_ready_o = idle_i && !starved;
    assign grant_d_o    = dmem_oe_i && dmem_ready_o;
    assign grant_i_o    = idle_i && !grant_d_o && fetch_waiting;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        starve_cnt_d = starve_cnt_q;
        if (grant_i_o) begin
            starve_cnt_d = '0;
        end else if (grant_d_o && fetch_waiting && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-outstanding RAM command/response port between the
//   instruction-fetch port (imem) and the data port (dmem). dmem has priority
//   but may overtake a waiting fetch at most STARVE_MAX times in a row.
//   Fetch requests are latched (imem has no ready) and a redirect that arrives
//   while a fetch is in flight squashes that fetch's response.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   imem_addr/imem_oe            fetch byte address / request pulse
//   imem_rdata/imem_valid        registered fetch data / one-cycle valid
//   dmem_addr/oe/wdata/we        data request (we==0 means read)
//   dmem_ready                   data request accepted this cycle
//   dmem_rdata/dmem_valid        registered load data / one-cycle valid
//   ram_cmd_valid/ready          RAM command handshake
//   ram_addr/ram_we/ram_wdata    RAM command fields, held while waiting
//   ram_rsp_valid/ram_rdata      RAM read response (reads only)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic                   imem_oe,
    output logic [DATA_W-1:0]      imem_rdata,
    output logic                   imem_valid,
    input  logic [ADDR_W-1:0]      dmem_addr,
    input  logic                   dmem_oe,
    input  logic [DATA_W-1:0]      dmem_wdata,
    input  logic [3:0]             dmem_we,
    output logic                   dmem_ready,
    output logic [DATA_W-1:0]      dmem_rdata,
    output logic                   dmem_valid,
    output logic                   ram_cmd_valid,
    input  logic                   ram_cmd_ready,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [3:0]             ram_we,
    output logic [DATA_W-1:0]      ram_wdata,
    input  logic                   ram_rsp_valid,
    input  logic [DATA_W-1:0]      ram_rdata
);

    state_e                 state_q, state_d;
    owner_e                 owner_q, owner_d;
    logic                   ipend_q, ipend_d;
    logic [IMEM_ADDR_W-1:0] ipend_addr_q, ipend_addr_d;
    logic                   squash_q, squash_d;
    logic [ADDR_W-1:0]      cmd_addr_q, cmd_addr_d;
    logic [3:0]             cmd_we_q, cmd_we_d;
    logic [DATA_W-1:0]      cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0]      imem_rdata_q, imem_rdata_d;
    logic                   imem_valid_q, imem_valid_d;
    logic [DATA_W-1:0]      dmem_rdata_q, dmem_rdata_d;
    logic                   dmem_valid_q, dmem_valid_d;

    logic                   grant_d, grant_i;
    logic [IMEM_ADDR_W-1:0] fetch_addr;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk          (clk),
        .rst          (rst),
        .idle_i       (state_q == IDLE),
        .dmem_oe_i    (dmem_oe),
        .imem_oe_i    (imem_oe),
        .ipend_i      (ipend_q),
        .dmem_ready_o (dmem_ready),
        .grant_d_o    (grant_d),
        .grant_i_o    (grant_i)
    );

    // A fresh fetch always supersedes the latched one.
    assign fetch_addr = imem_oe ? imem_addr : ipend_addr_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ipend_d      = ipend_q;
        ipend_addr_d = ipend_addr_q;
        squash_d     = squash_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_we_d     = cmd_we_q;
        cmd_wdata_d  = cmd_wdata_q;
        imem_rdata_d = imem_rdata_q;
        imem_valid_d = 1'b0;
        dmem_rdata_d = dmem_rdata_q;
        dmem_valid_d = 1'b0;

        // Fetch capture; the FSM below may consume it in the same cycle.
        if (imem_oe) begin
            ipend_d      = 1'b1;
            ipend_addr_d = imem_addr;
            // Any fetch in flight now belongs to a stale program counter.
            if ((state_q != IDLE) && (owner_q == OWN_I)) begin
                squash_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    cmd_addr_d  = dmem_addr;
                    cmd_we_d    = dmem_we;
                    cmd_wdata_d = dmem_wdata;
                    owner_d     = OWN_D;
                    state_d     = ISSUE;
                end else if (grant_i) begin
                    cmd_addr_d  = ADDR_W'(fetch_addr);
                    cmd_we_d    = 4'b0000;
                    cmd_wdata_d = '0;
                    ipend_d     = 1'b0;
                    owner_d     = OWN_I;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_cmd_ready) begin
                    state_d = (cmd_we_q == 4'b0000) ? WAIT : IDLE;
                end
            end
            WAIT: begin
                if (ram_rsp_valid) begin
                    state_d = IDLE;
                    if (owner_q == OWN_D) begin
                        dmem_rdata_d = ram_rdata;
                        dmem_valid_d = 1'b1;
                    end else if (squash_q || imem_oe) begin
                        // Redirected fetch (including a redirect arriving with
                        // the response): drop the data, the new fetch is pending.
                        squash_d = 1'b0;
                    end else begin
                        imem_rdata_d = ram_rdata;
                        imem_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            ipend_q      <= 1'b0;
            ipend_addr_q <= '0;
            squash_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_we_q     <= '0;
            cmd_wdata_q  <= '0;
            imem_rdata_q <= '0;
            imem_valid_q <= 1'b0;
            dmem_rdata_q <= '0;
            dmem_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ipend_q      <= ipend_d;
            ipend_addr_q <= ipend_addr_d;
            squash_q     <= squash_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_we_q     <= cmd_we_d;
            cmd_wdata_q  <= cmd_wdata_d;
            imem_rdata_q <= imem_rdata_d;
            imem_valid_q <= imem_valid_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_valid_q <= dmem_valid_d;
        end
    end

    assign ram_cmd_valid = (state_q == ISSUE);
    assign ram_addr      = cmd_addr_q;
    assign ram_we        = cmd_we_q;
    assign ram_wdata     = cmd_wdata_q;
    assign imem_rdata    = imem_rdata_q;
    assign imem_valid    = imem_valid_q;
    assign dmem_rdata    = dmem_rdata_q;
    assign dmem_valid    = dmem_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter: a behavioural RAM, a valid-pulse
//   scoreboard, a vector table of single transactions and hand-written
//   sequences for contention, starvation, stalled stores, squash and reset.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_oe;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] dmem_addr;
    logic        dmem_oe;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_we;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_valid;
    logic        ram_cmd_valid;
    logic        ram_cmd_ready;
    logic [31:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic        ram_rsp_valid;
    logic [31:0] ram_rdata;

    int checks   = 0;
    int failures = 0;

    int   rsp_lat    = 1;
    logic inject_req = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic        is_d;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_addr;
        logic [3:0]  exp_we;
    } vec_t;

    cmd_t        cmd_q[$];
    logic [31:0] i_exp[$];
    logic [31:0] d_exp[$];
    owner_e      vlog[$];
    vec_t        vecs[7];

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_oe       (imem_oe),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .dmem_addr     (dmem_addr),
        .dmem_oe       (dmem_oe),
        .dmem_wdata    (dmem_wdata),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .dmem_valid    (dmem_valid),
        .ram_cmd_valid (ram_cmd_valid),
        .ram_cmd_ready (ram_cmd_ready),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rsp_valid (ram_rsp_valid),
        .ram_rdata     (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_model_data(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0000_0013;
        return {a[15:0] ^ 16'h5A5A, a[15:0] ^ 16'h0F0F};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural RAM; works 2 time units after the falling edge so it sees
    // the inputs the bench drove on that edge.
    task automatic ram_model();
        int          cd = 0;
        logic [31:0] pend = '0;
        forever begin
            @(negedge clk);
            #2;
            ram_rsp_valid = 1'b0;
            if (inject_req) begin
                ram_rsp_valid = 1'b1;
                ram_rdata     = 32'hBAD0_BAD0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    ram_rsp_valid = 1'b1;
                    ram_rdata     = pend;
                end
            end
            if (ram_cmd_valid && ram_cmd_ready) begin
                cmd_q.push_back('{ram_addr, ram_we, ram_wdata});
                if (ram_we == 4'h0) begin
                    cd   = rsp_lat;
                    pend = ram_model_data(ram_addr);
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (imem_valid) begin
                vlog.push_back(OWN_I);
                if (i_exp.size() == 0) check("imem_valid_unexpected", 64'(imem_valid), 64'd0);
                else check("imem_rdata", 64'(imem_rdata), 64'(i_exp.pop_front()));
            end
            if (dmem_valid) begin
                vlog.push_back(OWN_D);
                if (d_exp.size() == 0) check("dmem_valid_unexpected", 64'(dmem_valid), 64'd0);
                else check("dmem_rdata", 64'(dmem_rdata), 64'(d_exp.pop_front()));
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic dmem_req(input logic [31:0] a, input logic [3:0] we,
                            input logic [31:0] wd, input string name);
        int n = 0;
        dmem_addr  = a;
        dmem_we    = we;
        dmem_wdata = wd;
        dmem_oe    = 1'b1;
        while (!dmem_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_accept_in_time"}, 64'(n < 200), 64'd1);
        if (we == 4'h0) d_exp.push_back(ram_model_data(a));
        @(negedge clk);
        dmem_oe = 1'b0;
    endtask

    task automatic fetch_req(input logic [15:0] a);
        imem_addr = a;
        imem_oe   = 1'b1;
        @(negedge clk);
        imem_oe   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((i_exp.size() != 0 || d_exp.size() != 0 || dut.state_q != IDLE || dut.ipend_q)
               && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, "_drained"}, 64'(i_exp.size() + d_exp.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] exp_order[6];
        int          i_count;

        vecs[0] = '{1'b0, 4'h0, 32'h0000_0004, 32'h0,          1, 32'h0000_0004, 4'h0};
        vecs[1] = '{1'b1, 4'h0, 32'h0000_8000, 32'h0,          2, 32'h0000_8000, 4'h0};
        vecs[2] = '{1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344,  1, 32'h0000_0010, 4'hF};
        vecs[3] = '{1'b0, 4'h0, 32'h0000_FFFC, 32'h0,          4, 32'h0000_FFFC, 4'h0};
        vecs[4] = '{1'b1, 4'h0, 32'hFFFF_FFFC, 32'h0,          1, 32'hFFFF_FFFC, 4'h0};
        vecs[5] = '{1'b1, 4'h8, 32'h0000_0003, 32'hA5A5_A5A5,  1, 32'h0000_0003, 4'h8};
        vecs[6] = '{1'b0, 4'h0, 32'h0000_8002, 32'h0,          2, 32'h0000_8002, 4'h0};

        rst = 1'b1; imem_addr = '0; imem_oe = 1'b0;
        dmem_addr = '0; dmem_oe = 1'b0; dmem_wdata = '0; dmem_we = '0;
        ram_cmd_ready = 1'b1; ram_rsp_valid = 1'b0; ram_rdata = '0;

        fork
            ram_model();
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_valids", 64'({imem_valid, dmem_valid, ram_cmd_valid}), 64'd0);
        check("reset_data", {imem_rdata, dmem_rdata}, 64'd0);
        check("reset_cmd", {ram_addr, ram_wdata}, 64'd0);
        check("reset_we", 64'(ram_we), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Lone fetch: cmd at T+1, valid at T+3
        cmd_q.delete(); vlog.delete();
        i_exp.push_back(32'h0000_0013);
        fetch_req(16'h0040);
        check("lone_cmd_valid", 64'(ram_cmd_valid), 64'd1);
        check("lone_ram_addr", 64'(ram_addr), 64'h40);
        check("lone_ram_we", 64'(ram_we), 64'd0);
        @(negedge clk);
        check("lone_valid_early", 64'(imem_valid), 64'd0);
        @(negedge clk);
        check("lone_valid_t3", 64'(imem_valid), 64'd1);
        check("lone_rdata_t3", 64'(imem_rdata), 64'h13);
        check("lone_dmem_valid", 64'(dmem_valid), 64'd0);
        drain("lone");

        // Vector table
        foreach (vecs[k]) begin
            cmd_q.delete();
            rsp_lat = vecs[k].lat;
            if (vecs[k].is_d) begin
                dmem_req(vecs[k].addr, vecs[k].we, vecs[k].wdata, $sformatf("vec%0d", k));
            end else begin
                i_exp.push_back(ram_model_data(vecs[k].exp_addr));
                fetch_req(vecs[k].addr[15:0]);
            end
            drain($sformatf("vec%0d", k));
            check($sformatf("vec%0d_ncmd", k), 64'(cmd_q.size()), 64'd1);
            if (cmd_q.size() != 0) begin
                check($sformatf("vec%0d_addr", k), 64'(cmd_q[0].addr), 64'(vecs[k].exp_addr));
                check($sformatf("vec%0d_we", k), 64'(cmd_q[0].we), 64'(vecs[k].exp_we));
                if (vecs[k].exp_we != 4'h0)
                    check($sformatf("vec%0d_wdata", k), 64'(cmd_q[0].wdata), 64'(vecs[k].wdata));
            end
        end
        rsp_lat = 1;

        // Contention: dmem first, fetch latched
        cmd_q.delete(); vlog.delete();
        i_exp.push_back(ram_model_data(32'h0000_0044));
        imem_addr = 16'h0044;
        imem_oe   = 1'b1;
        dmem_req(32'h0000_1000, 4'h0, 32'h0, "cont");
        imem_oe   = 1'b0;
        check("cont_ipend", 64'(dut.ipend_q), 64'd1);
        check("cont_starve_one", 64'(dut.u_grant.starve_cnt_q), 64'd1);
        drain("cont");
        check("cont_ncmd", 64'(cmd_q.size()), 64'd2);
        if (cmd_q.size() == 2) begin
            check("cont_first_addr", 64'(cmd_q[0].addr), 64'h1000);
            check("cont_second_addr", 64'(cmd_q[1].addr), 64'h44);
        end
        check("cont_nvalid", 64'(vlog.size()), 64'd2);
        if (vlog.size() == 2) check("cont_order", 64'({vlog[0], vlog[1]}), 64'({OWN_D, OWN_I}));
        check("cont_starve_zero", 64'(dut.u_grant.starve_cnt_q), 64'd0);

        // Starvation bound: 4 dmem grants, then the fetch
        cmd_q.delete(); vlog.delete();
        i_exp.push_back(ram_model_data(32'h0000_0100));
        imem_addr = 16'h0100;
        imem_oe   = 1'b1;
        dmem_req(32'h0000_3000, 4'h0, 32'h0, "starve0");
        imem_oe   = 1'b0;
        for (int k = 1; k < 5; k++)
            dmem_req(32'h0000_3000 + 32'(4 * k), 4'h0, 32'h0, $sformatf("starve%0d", k));
        drain("starve");
        exp_order = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h0100, 32'h3010};
        check("starve_ncmd", 64'(cmd_q.size()), 64'd6);
        if (cmd_q.size() == 6)
            foreach (exp_order[k])
                check($sformatf("starve_order%0d", k), 64'(cmd_q[k].addr), 64'(exp_order[k]));

        // Store with RAM stalled for 3 cycles
        cmd_q.delete(); vlog.delete();
        ram_cmd_ready = 1'b0;
        dmem_req(32'h0000_2002, 4'b0011, 32'hDEAD_BEEF, "store");
        for (int k = 0; k < 3; k++) begin
            check($sformatf("store_valid%0d", k), 64'(ram_cmd_valid), 64'd1);
            check($sformatf("store_cmd%0d", k), {ram_addr, ram_wdata}, 64'h0000_2002_DEAD_BEEF);
            check($sformatf("store_we%0d", k), 64'(ram_we), 64'h3);
            if (k < 2) @(negedge clk);
        end
        ram_cmd_ready = 1'b1;
        @(negedge clk);
        check("store_idle", 64'({ram_cmd_valid, dmem_ready}), 64'b01);
        repeat (4) @(negedge clk);
        check("store_no_valid", 64'(vlog.size()), 64'd0);

        // Redirect squash
        cmd_q.delete(); vlog.delete();
        rsp_lat = 3;
        i_exp.push_back(ram_model_data(32'h0000_0080));
        fetch_req(16'h0010);
        @(negedge clk);
        check("squash_in_wait", 64'(dut.state_q == WAIT), 64'd1);
        fetch_req(16'h0080);
        drain("squash");
        check("squash_ncmd", 64'(cmd_q.size()), 64'd2);
        if (cmd_q.size() == 2)
            check("squash_addrs", {cmd_q[0].addr, cmd_q[1].addr}, 64'h0000_0010_0000_0080);
        i_count = 0;
        foreach (vlog[k]) if (vlog[k] == OWN_I) i_count++;
        check("squash_one_ivalid", 64'(i_count), 64'd1);

        // Reset mid-WAIT, then stray responses
        vlog.delete();
        rsp_lat = 5;
        fetch_req(16'h0200);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_outputs", 64'({imem_valid, dmem_valid, ram_cmd_valid, ram_we}), 64'd0);
        check("rstw_data", {imem_rdata, dmem_rdata}, 64'd0);
        rst        = 1'b0;
        inject_req = 1'b1;
        @(negedge clk);
        inject_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rstw_quiet%0d", k), 64'({imem_valid, dmem_valid, ram_cmd_valid}), 64'd0);
            @(negedge clk);
        end
        check("rstw_idle", 64'(dut.state_q == IDLE), 64'd1);
        check("rstw_no_valid", 64'(vlog.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
